// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch_stage and the instruction memory.
interface fetch_stage_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_data;
   logic        imem_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_data,
      input  imem_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_data,
      output imem_valid
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests and fills the IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pc_next,
   input  logic        stall,
   input  logic        flush,
   input  logic [15:0] redirect_pc,
   fetch_stage_if.master imem,
   output logic [15:0] pc,
   output logic [15:0] fetch_instr,
   output logic        if_id_valid,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count,
`endif
   output logic        halted
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [15:0] if_id_instr_q, if_id_instr_d;
   logic [15:0] if_id_pc_q, if_id_pc_d;
   logic        halted_q, halted_d;
   logic        discard_q, discard_d;
   logic [15:0] buffer_q, buffer_d;

   logic        adv_en;
   logic [15:0] adv_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         if_id_valid_q <= 1'b0;
         if_id_instr_q <= 16'h0000;
         if_id_pc_q    <= 16'h0000;
         halted_q      <= 1'b0;
         discard_q     <= 1'b0;
         buffer_q      <= 16'h0000;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_pc_q    <= if_id_pc_d;
         halted_q      <= halted_d;
         discard_q     <= discard_d;
         buffer_q      <= buffer_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_id_valid_d = if_id_valid_q;
      if_id_instr_d = if_id_instr_q;
      if_id_pc_d    = if_id_pc_q;
      halted_d      = halted_q;
      discard_d     = discard_q;
      buffer_d      = buffer_q;
      adv_en        = 1'b0;
      adv_word      = imem.imem_data;

      unique case (state_q)
         FETCH: begin
            if (imem.imem_valid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
               end else if (stall) begin
                  buffer_d = imem.imem_data;
                  state_d  = HOLD;
               end else begin
                  adv_en = 1'b1;
               end
            end
         end
         HOLD: begin
            if (!stall) begin
               adv_en   = 1'b1;
               adv_word = buffer_q;
               state_d  = FETCH;
            end
         end
         HALTED: begin
            if (!stall) begin
               if_id_valid_d = 1'b0;
            end
         end
         default: state_d = FETCH;
      endcase

      // A HLT word enters IF/ID but freezes the PC instead of taking pc_next.
      if (adv_en) begin
         if_id_valid_d = 1'b1;
         if_id_instr_d = adv_word;
         if_id_pc_d    = pc_q;
         if (adv_word[15:12] == HLT_OPCODE) begin
            state_d  = HALTED;
            halted_d = 1'b1;
         end else begin
            pc_d = pc_next;
         end
      end

      // Redirect overrides everything; an in-flight response must be thrown away when it lands.
      if (flush) begin
         if_id_valid_d = 1'b0;
         pc_d          = redirect_pc;
         state_d       = FETCH;
         halted_d      = 1'b0;
         buffer_d      = 16'h0000;
         discard_d     = (state_q == FETCH) && !imem.imem_valid;
      end
   end

   assign imem.imem_req  = rst_n && (state_q == FETCH);
   assign imem.imem_addr = pc_q;
   assign pc             = pc_q;
   assign fetch_instr    = imem.imem_valid ? imem.imem_data : buffer_q;
   assign if_id_valid    = if_id_valid_q;
   assign if_id_instr    = if_id_instr_q;
   assign if_id_pc       = if_id_pc_q;
   assign halted         = halted_q;

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_count_q, flush_count_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= 16'h0000;
         flush_count_q  <= 16'h0000;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   // Both counters saturate rather than wrap.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (((state_q == HOLD) || (stall && if_id_valid_q)) && (stall_cycles_q != 16'hFFFF)) begin
         stall_cycles_d = stall_cycles_q + 16'd1;
      end
      if (flush && (flush_count_q != 16'hFFFF)) begin
         flush_count_d = flush_count_q + 16'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule
